dds_spi_ctrl: RTL and testbench
===============================

# dds_spi_ctrl

SPI configuration controller for the DDS core. Deserialises 24-bit SPI write frames (lines already synchronised into `clk` upstream), decodes them into a double-buffered register file of two frequency tuning words, two phase offsets and a control byte, and drives the active tuning values into the phase accumulator datapath. Shadow registers are written per frame. Active registers update atomically only on an explicit LOAD command, so the DDS never runs on a half-written tuning word.

## Interface
Parameters:
- `FREQ_W`, default 16: frequency tuning word width, at most 16.
- `PHASE_W`, default 8: phase offset width, at most 16.

Ports:
- `clk` in 1: system clock. One clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `spi_clock` in 1: SPI SCK, already synchronised to `clk`. Mode 0; data is sampled on SCK rising edge.
- `spi_cs_n` in 1: SPI chip select, active low, synchronised.
- `spi_mosi` in 1: SPI data, MSB first, synchronised.
- `freq0` out FREQ_W: active tuning word 0.
- `freq1` out FREQ_W: active tuning word 1.
- `phase0` out PHASE_W: active phase offset 0.
- `phase1` out PHASE_W: active phase offset 1.
- `acc_clear` out 1: level output, holds the phase accumulator cleared. Active CTRL bit 0.
- `out_enable` out 1: level output, DDS output enable. Active CTRL bit 1.
- `load_pulse` out 1: 1-cycle pulse when the active registers update.
- `frame_err` out 1: 1-cycle pulse on a malformed frame.

## Operation
- Frame format, 24 bits: [23:20] addr, [19:16] reserved (ignored), [15:0] data.
- Address map:
  - 0 FREQ0: shadow ← data[FREQ_W-1:0].
  - 1 FREQ1: shadow ← data[FREQ_W-1:0].
  - 2 PHASE0: shadow ← data[PHASE_W-1:0].
  - 3 PHASE1: shadow ← data[PHASE_W-1:0].
  - 4 CTRL: shadow ← data[1:0].
  - 0xF LOAD: all active registers ← their shadows in the same cycle, and `load_pulse` fires.
  - Other addresses: frame is accepted and ignored. No error.
- Edge detection: a registered copy of `spi_clock` is kept. Rising edge = prev 0 and current 1.
- FSM states: IDLE, SHIFT, COMMIT, ERROR.
  - IDLE: bit counter is 0. `spi_cs_n`=0 → SHIFT.
  - SHIFT: on each SCK rising edge, shift `spi_mosi` in and increment the counter (5 bits, saturating at 25).
  - SHIFT exit: `spi_cs_n`=1 with count==24 → COMMIT. `spi_cs_n`=1 with any other count → ERROR.
  - COMMIT: one cycle. Performs the decoded write or LOAD, then goes to IDLE.
  - ERROR: one cycle. Pulses `frame_err`, writes nothing, then goes to IDLE.
- Overlong frames (more than 24 edges) count to 25. Release of `spi_cs_n` then gives ERROR.
- SCK edges while `spi_cs_n`=1 are ignored.
- `spi_cs_n` falling during COMMIT or ERROR is honoured one cycle later: IDLE sees `cs_n`=0 and enters SHIFT. An SCK edge in that single cycle is dropped. The host must leave at least 2 `clk` cycles between frames.
- Shadow writes never change the outputs. Only LOAD changes `freq*`, `phase*`, `acc_clear` and `out_enable`.

## Timing
- Reset (asynchronous, `rst_n`=0): FSM → IDLE, counter and shift register cleared, all shadow and active registers cleared.
- Output values in reset:
  - `freq0`, `freq1`, `phase0`, `phase1` = 0.
  - `acc_clear` = 1. The reset value of CTRL is 2'b01, so the accumulator is held cleared until the first LOAD.
  - `out_enable` = 0.
  - `load_pulse`, `frame_err` = 0.
- Reset asserted mid-frame: the partial frame is discarded. After release the FSM waits in IDLE. If `spi_cs_n` is already low, it enters SHIFT and the trailing frame is rejected as ERROR at CS release, because its count is not 24.
- Latency:
  - SCK rising edge at the synchroniser output → bit shifted on the next `clk` edge after edge detection (1 cycle).
  - `spi_cs_n` rise → COMMIT on the next cycle.
  - Active registers and `load_pulse` are updated at the end of the COMMIT cycle, so they are visible 2 cycles after the `cs_n` rise.
- `load_pulse` and `frame_err` are registered and never high in the same cycle.
- Minimum SCK high and low time: 2 `clk` cycles each, as seen after the synchroniser.

## Test plan
- Reset: hold `rst_n`=0 → all outputs 0 except `acc_clear`=1. Release with no SPI traffic → outputs unchanged for 100 cycles.
- Write then load: frame 0x0_0_1234 (FREQ0), then frame 0xF_0_0000 (LOAD) → `freq0` stays 0 after the first frame. After LOAD, `freq0`=0x1234, exactly one `load_pulse`, and `freq1`=0.
- Atomic control: write PHASE1=0x00A5, FREQ1=0xBEEF and CTRL=0x0002, then LOAD → `phase1`=0xA5, `freq1`=0xBEEF, `acc_clear`=0 and `out_enable`=1, all changing in the same cycle.
- Short and long frames: 23-bit frame to addr 0, then 25-bit frame to addr 1 → one `frame_err` pulse per frame, shadows unchanged. A subsequent LOAD leaves `freq0`=`freq1`=0.
- Reset mid-frame: assert `rst_n` after 12 bits of a FREQ0 frame, release while `cs_n` is still low, finish the frame → `frame_err` pulse, and `freq0` is still 0 after LOAD.
- Ignored address: frame 0x7_0_FFFF, then LOAD → no `frame_err`, and all active registers keep their prior values.

Source files
------------

// File: rtl/dds_spi_ctrl_if.sv
// SPI bus bundle between the configuration host and the DDS controller.
// The lines are assumed to be synchronised into the system clock domain
// before they reach this bundle.
interface dds_spi_ctrl_if;
  logic spi_clock;
  logic spi_cs_n;
  logic spi_mosi;

  modport master (
    output spi_clock,
    output spi_cs_n,
    output spi_mosi
  );

  modport slave (
    input spi_clock,
    input spi_cs_n,
    input spi_mosi
  );
endinterface

// File: rtl/dds_spi_ctrl.sv
// SPI configuration controller for the DDS core.
// Receives 24-bit write frames (addr[23:20], reserved[19:16], data[15:0]),
// writes shadow registers per frame and copies every shadow into the active
// registers at once on a LOAD command, so the phase accumulator never sees
// a half-written tuning word.
module dds_spi_ctrl #(
  parameter int FREQ_W  = 16,
  parameter int PHASE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  dds_spi_ctrl_if.slave      spi,
  output logic [FREQ_W-1:0]  freq0,
  output logic [FREQ_W-1:0]  freq1,
  output logic [PHASE_W-1:0] phase0,
  output logic [PHASE_W-1:0] phase1,
  output logic               acc_clear,
  output logic               out_enable,
  output logic               load_pulse,
  output logic               frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT,
    ERROR
  } state_t;

  localparam logic [4:0] COUNT_FULL = 5'd24;
  localparam logic [4:0] COUNT_MAX  = 5'd25;

  localparam logic [3:0] ADDR_FREQ0  = 4'h0;
  localparam logic [3:0] ADDR_FREQ1  = 4'h1;
  localparam logic [3:0] ADDR_PHASE0 = 4'h2;
  localparam logic [3:0] ADDR_PHASE1 = 4'h3;
  localparam logic [3:0] ADDR_CTRL   = 4'h4;
  localparam logic [3:0] ADDR_LOAD   = 4'hF;

  state_t             state;
  logic               sck_prev;
  logic [4:0]         bit_count;
  logic [23:0]        shift_reg;

  logic [FREQ_W-1:0]  freq0_sh;
  logic [FREQ_W-1:0]  freq1_sh;
  logic [PHASE_W-1:0] phase0_sh;
  logic [PHASE_W-1:0] phase1_sh;
  logic [1:0]         ctrl_sh;
  logic [1:0]         ctrl_act;

  logic               sck_rise;
  logic [3:0]         frame_addr;
  logic [15:0]        frame_data;
  logic               unused_reserved;

  assign sck_rise        = spi.spi_clock & ~sck_prev;
  assign frame_addr      = shift_reg[23:20];
  assign frame_data      = shift_reg[15:0];
  assign unused_reserved = ^shift_reg[19:16];

  assign acc_clear  = ctrl_act[0];
  assign out_enable = ctrl_act[1];

  // Frame receiver FSM: edge detect, shift, then commit or reject on CS release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sck_prev   <= 1'b0;
      bit_count  <= '0;
      shift_reg  <= '0;
      freq0_sh   <= '0;
      freq1_sh   <= '0;
      phase0_sh  <= '0;
      phase1_sh  <= '0;
      ctrl_sh    <= 2'b01;
      freq0      <= '0;
      freq1      <= '0;
      phase0     <= '0;
      phase1     <= '0;
      ctrl_act   <= 2'b01;
      load_pulse <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sck_prev   <= spi.spi_clock;
      load_pulse <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          bit_count <= '0;
          if (!spi.spi_cs_n) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (spi.spi_cs_n) begin
            state <= (bit_count == COUNT_FULL) ? COMMIT : ERROR;
          end else if (sck_rise) begin
            shift_reg <= {shift_reg[22:0], spi.spi_mosi};
            if (bit_count != COUNT_MAX) begin
              bit_count <= bit_count + 5'd1;
            end
          end
        end
        COMMIT: begin
          state <= IDLE;
          case (frame_addr)
            ADDR_FREQ0:  freq0_sh  <= frame_data[FREQ_W-1:0];
            ADDR_FREQ1:  freq1_sh  <= frame_data[FREQ_W-1:0];
            ADDR_PHASE0: phase0_sh <= frame_data[PHASE_W-1:0];
            ADDR_PHASE1: phase1_sh <= frame_data[PHASE_W-1:0];
            ADDR_CTRL:   ctrl_sh   <= frame_data[1:0];
            ADDR_LOAD: begin
              freq0      <= freq0_sh;
              freq1      <= freq1_sh;
              phase0     <= phase0_sh;
              phase1     <= phase1_sh;
              ctrl_act   <= ctrl_sh;
              load_pulse <= 1'b1;
            end
            default: ;
          endcase
        end
        ERROR: begin
          state     <= IDLE;
          frame_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_spi_ctrl.sv
// Self-checking bench for dds_spi_ctrl: directed frames from the test plan
// followed by randomized frames, all checked against a register-file model.
module tb_dds_spi_ctrl;

  localparam int FREQ_W  = 16;
  localparam int PHASE_W = 8;
  localparam logic [15:0] FREQ_MASK  = 16'((1 << FREQ_W) - 1);
  localparam logic [15:0] PHASE_MASK = 16'((1 << PHASE_W) - 1);

  logic clk = 1'b0;
  logic rst_n;

  logic [FREQ_W-1:0]  freq0;
  logic [FREQ_W-1:0]  freq1;
  logic [PHASE_W-1:0] phase0;
  logic [PHASE_W-1:0] phase1;
  logic acc_clear;
  logic out_enable;
  logic load_pulse;
  logic frame_err;

  int checks  = 0;
  int errors  = 0;
  int overlap = 0;

  // Model: index 0 freq0, 1 freq1, 2 phase0, 3 phase1, 4 ctrl
  logic [15:0] m_sh  [5];
  logic [15:0] m_act [5];

  dds_spi_ctrl_if spi_bus ();

  dds_spi_ctrl #(
    .FREQ_W  (FREQ_W),
    .PHASE_W (PHASE_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi        (spi_bus.slave),
    .freq0      (freq0),
    .freq1      (freq1),
    .phase0     (phase0),
    .phase1     (phase1),
    .acc_clear  (acc_clear),
    .out_enable (out_enable),
    .load_pulse (load_pulse),
    .frame_err  (frame_err)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Track any cycle where both pulses are high together
  always @(negedge clk) begin
    if (load_pulse && frame_err) overlap++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, " freq0"},      32'(freq0),      32'(m_act[0]));
    checkOutput({tag, " freq1"},      32'(freq1),      32'(m_act[1]));
    checkOutput({tag, " phase0"},     32'(phase0),     32'(m_act[2]));
    checkOutput({tag, " phase1"},     32'(phase1),     32'(m_act[3]));
    checkOutput({tag, " acc_clear"},  32'(acc_clear),  32'(m_act[4][0]));
    checkOutput({tag, " out_enable"}, 32'(out_enable), 32'(m_act[4][1]));
  endtask

  task automatic modelReset();
    for (int i = 0; i < 5; i++) begin
      m_sh[i]  = 16'h0;
      m_act[i] = 16'h0;
    end
    m_sh[4]  = 16'h1;
    m_act[4] = 16'h1;
  endtask

  task automatic modelFrame(input logic [31:0] frame, input int nbits,
                            output bit exp_load, output bit exp_err);
    logic [3:0]  addr;
    logic [15:0] data;
    exp_load = 1'b0;
    exp_err  = (nbits != 24);
    addr = frame[23:20];
    data = frame[15:0];
    if (!exp_err) begin
      case (addr)
        4'h0: m_sh[0] = data & FREQ_MASK;
        4'h1: m_sh[1] = data & FREQ_MASK;
        4'h2: m_sh[2] = data & PHASE_MASK;
        4'h3: m_sh[3] = data & PHASE_MASK;
        4'h4: m_sh[4] = data & 16'h3;
        4'hF: begin
          for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
          exp_load = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic startFrame();
    spi_bus.spi_cs_n = 1'b0;
    waitCycles(2);
  endtask

  task automatic shiftBits(input logic [31:0] frame, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      spi_bus.spi_mosi  = frame[i];
      spi_bus.spi_clock = 1'b0;
      waitCycles(2);
      spi_bus.spi_clock = 1'b1;
      waitCycles(2);
    end
  endtask

  // Release CS and check the commit/error timing and the resulting outputs
  task automatic endFrame(input logic [31:0] frame, input int nbits, input string tag);
    bit exp_load;
    bit exp_err;
    spi_bus.spi_clock = 1'b0;
    waitCycles(2);
    spi_bus.spi_cs_n = 1'b1;
    @(negedge clk);
    checkOutput({tag, " early pulses"}, {30'h0, load_pulse, frame_err}, 32'h0);
    checkState({tag, " hold"});
    modelFrame(frame, nbits, exp_load, exp_err);
    @(negedge clk);
    checkOutput({tag, " load_pulse"}, 32'(load_pulse), 32'(exp_load));
    checkOutput({tag, " frame_err"},  32'(frame_err),  32'(exp_err));
    checkState({tag, " after"});
    @(negedge clk);
    checkOutput({tag, " pulse width"}, {30'h0, load_pulse, frame_err}, 32'h0);
    waitCycles(2);
  endtask

  task automatic applyStimulus(input logic [31:0] frame, input int nbits, input string tag);
    startFrame();
    shiftBits(frame, nbits - 1, 0);
    endFrame(frame, nbits, tag);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    spi_bus.spi_clock = 1'b0;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkState(tag);
    checkOutput({tag, " pulses"}, {30'h0, load_pulse, frame_err}, 32'h0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(2);
  endtask

  // Main stimulus sequence
  initial begin
    int pulses;
    logic [31:0] rnd;
    logic [3:0]  addr;
    int nbits;
    int sel;

    rst_n = 1'b0;
    spi_bus.spi_cs_n  = 1'b1;
    spi_bus.spi_clock = 1'b0;
    spi_bus.spi_mosi  = 1'b0;
    modelReset();
    waitCycles(3);
    checkState("reset");
    checkOutput("reset pulses", {30'h0, load_pulse, frame_err}, 32'h0);

    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (load_pulse || frame_err) pulses++;
    end
    checkState("idle100");
    checkOutput("idle100 pulses", 32'(pulses), 32'h0);

    applyStimulus(32'h00_1234, 24, "wr freq0");
    applyStimulus(32'hF0_0000, 24, "load1");

    applyStimulus(32'h30_00A5, 24, "wr phase1");
    applyStimulus(32'h10_BEEF, 24, "wr freq1");
    applyStimulus(32'h40_0002, 24, "wr ctrl");
    applyStimulus(32'hF0_0000, 24, "load2");

    doReset("reset2");
    applyStimulus(32'h00_5A5A >> 1, 23, "short");
    applyStimulus({7'h0, 24'h10_7777, 1'b1}, 25, "long");
    applyStimulus(32'hF0_0000, 24, "load3");

    startFrame();
    shiftBits(32'h00_ABCD, 23, 12);
    doReset("midreset");
    shiftBits(32'h00_ABCD, 11, 0);
    endFrame(32'h00_ABCD, 12, "tail");
    applyStimulus(32'hF0_0000, 24, "load4");

    applyStimulus(32'h00_1111, 24, "pre freq0");
    applyStimulus(32'h40_0003, 24, "pre ctrl");
    applyStimulus(32'hF0_0000, 24, "pre load");
    applyStimulus(32'h70_FFFF, 24, "ignored");
    applyStimulus(32'hF0_0000, 24, "load5");

    for (int n = 0; n < 60; n++) begin
      rnd = $urandom;
      sel = $urandom_range(0, 7);
      addr = (sel == 5 || sel == 6) ? 4'hF : (sel == 7) ? 4'h7 : 4'(sel);
      if ($urandom_range(0, 7) == 0) begin
        sel = $urandom_range(0, 3);
        nbits = (sel < 2) ? 22 + sel : 23 + sel;
      end else begin
        nbits = 24;
      end
      applyStimulus({8'h0, addr, rnd[19:0]}, nbits, "random");
    end

    checkOutput("pulse overlap", 32'(overlap), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
